// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, Data_width data bits LSB first, optional parity, stop.
// One bit per CLK cycle. Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [Data_width-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic                  tx_reg;
    logic                  busy_reg;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_second_reg;
`endif

    // The line registers are updated from the state being left, so each
    // state's bit appears one cycle after the state is entered. This is
    // what makes the start bit follow the accepting edge by one cycle, and
    // the single idle-high cycle between back-to-back frames falls out of it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= IDLE;
            bit_cnt_reg     <= '0;
            data_reg        <= '0;
            par_en_reg      <= 1'b0;
            par_bit_reg     <= 1'b0;
            tx_reg          <= 1'b1;
            busy_reg        <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_second_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (DATA_VALID) begin
                        data_reg    <= P_DATA;
                        par_en_reg  <= PAR_EN;
                        par_bit_reg <= (^P_DATA) ^ PAR_TYP;
                        state_reg   <= START;
                    end
                end
                START: begin
                    tx_reg      <= 1'b0;
                    busy_reg    <= 1'b1;
                    bit_cnt_reg <= '0;
                    state_reg   <= DATA;
                end
                DATA: begin
                    tx_reg      <= data_reg[bit_cnt_reg];
                    busy_reg    <= 1'b1;
                    bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg <= par_en_reg ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    tx_reg    <= par_bit_reg;
                    busy_reg  <= 1'b1;
                    state_reg <= STOP;
                end
                STOP: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop_second_reg) begin
                        stop_second_reg <= 1'b1;
                    end else begin
                        stop_second_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end
`else
                    state_reg <= IDLE;
`endif
                end
                default: begin
                    tx_reg    <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

endmodule
